// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier family: FSM states, radix-4
// digit codes, and helpers for recoding and counter sizing.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_P1   = 3'd1,
    BD_P2   = 3'd2,
    BD_M1   = 3'd3,
    BD_M2   = 3'd4
  } booth_digit_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  // Radix-4 recoding of {q[i+1], q[i], q[i-1]}.
  function automatic booth_digit_t booth_recode(input logic [2:0] triplet);
    case (triplet)
      3'b001, 3'b010: return BD_P1;
      3'b011:         return BD_P2;
      3'b100:         return BD_M2;
      3'b101, 3'b110: return BD_M1;
      default:        return BD_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Combinational radix-4 Booth partial-product selector; also used by the
// pipelined array variant.
module booth_r4_encoder
  import mult_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [2:0]       i_triplet,
  input  logic [WIDTH+1:0] i_mcand,
  output logic [WIDTH+2:0] o_pp
);

  booth_digit_t     w_digit;
  logic             w_neg;
  logic [WIDTH+2:0] w_mag;

  always_comb begin
    w_digit = booth_recode(i_triplet);
    w_neg   = (w_digit == BD_M1) || (w_digit == BD_M2);
    case (w_digit)
      BD_P2, BD_M2: w_mag = {i_mcand, 1'b0};
      BD_P1, BD_M1: w_mag = {i_mcand[WIDTH+1], i_mcand};
      default:      w_mag = '0;
    endcase
    // Negative digits use one's complement plus a carry-in of one.
    o_pp = (w_neg ? ~w_mag : w_mag) + {{(WIDTH+2){1'b0}}, w_neg};
  end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Iterative radix-4 Booth multiplier, two multiplier bits per cycle, with
// run-time signed/unsigned mode and the op_start/op_clear/op_done handshake.
module booth_r4_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int XW    = WIDTH + 2;
  localparam int ITER  = XW / 2;
  localparam int CNT_W = clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [XW-1:0]      r_acc_hi;
  logic [XW-1:0]      r_acc_lo;
  logic               r_q_m1;
  logic [XW-1:0]      r_mcand;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_result;

  logic [XW-1:0]      w_mult_ext;
  logic [XW-1:0]      w_mcand_ext;
  logic [XW:0]        w_pp;
  logic [XW:0]        w_sum;
  logic [XW-1:0]      w_next_hi;
  logic [XW-1:0]      w_next_lo;

  assign w_mult_ext  = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                   : {2'b00, multiplier};
  assign w_mcand_ext = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                   : {2'b00, multiplicand};

  booth_r4_encoder #(.WIDTH(WIDTH)) u_encoder (
    .i_triplet (({r_acc_lo[1:0], r_q_m1})),
    .i_mcand   (r_mcand),
    .o_pp      (w_pp)
  );

  // One extra sum bit keeps the add exact; the >>>2 then folds it back.
  assign w_sum     = {r_acc_hi[XW-1], r_acc_hi} + w_pp;
  assign w_next_hi = {w_sum[XW], w_sum[XW:2]};
  assign w_next_lo = {w_sum[1:0], r_acc_lo[XW-1:2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: assign a default before any branch so no path infers a latch.
    w_next_state = r_state;
    if (op_clear) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (op_start) w_next_state = ST_EXEC;
        ST_EXEC: if (r_count == LAST_CNT) w_next_state = ST_DONE;
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_q_m1   <= 1'b0;
      r_mcand  <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else if (op_clear) begin
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_q_m1   <= 1'b0;
      r_mcand  <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_start) begin
            r_acc_hi <= '0;
            r_acc_lo <= w_mult_ext;
            r_q_m1   <= 1'b0;
            r_mcand  <= w_mcand_ext;
            r_count  <= '0;
          end
        end
        ST_EXEC: begin
          r_acc_hi <= w_next_hi;
          r_acc_lo <= w_next_lo;
          r_q_m1   <= r_acc_lo[1];
          r_count  <= r_count + CNT_W'(1);
          if (r_count == LAST_CNT) r_result <= {w_next_hi[WIDTH-3:0], w_next_lo};
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == ST_EXEC);
  assign op_done = (r_state == ST_DONE);
  assign result  = r_result;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Directed bench for booth_r4_multiplier: 64-bit and 8-bit instances checked
// against hand-computed products, latency, clear/abort and async reset.
module tb_booth_r4_multiplier;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic         start64 = 0, clear64 = 0, sm64 = 0;
  logic [63:0]  mult64 = '0, mcand64 = '0;
  logic         busy64, done64;
  logic [127:0] res64;

  logic         start8 = 0, clear8 = 0, sm8 = 0;
  logic [7:0]   mult8 = '0, mcand8 = '0;
  logic         busy8, done8;
  logic [15:0]  res8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_r4_multiplier #(.WIDTH(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .op_start(start64), .op_clear(clear64),
    .signed_mode(sm64), .multiplier(mult64), .multiplicand(mcand64),
    .busy(busy64), .op_done(done64), .result(res64)
  );

  booth_r4_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .op_start(start8), .op_clear(clear8),
    .signed_mode(sm8), .multiplier(mult8), .multiplicand(mcand8),
    .busy(busy8), .op_done(done8), .result(res8)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start with op_start held high, scramble operands after the load edge,
  // wait for op_done, verify hold in DONE, then clear.
  task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic sm, input logic [127:0] exp);
    int cyc;
    mult64 = a; mcand64 = b; sm64 = sm; start64 = 1'b1;
    step();
    check({tag, "_busy_at_load"}, busy64, 1);
    mult64 = ~a; mcand64 = b ^ 64'h5A5A; sm64 = ~sm;
    cyc = 0;
    while (!done64 && cyc < 100) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 33);
    check({tag, "_result"}, res64, exp);
    check({tag, "_busy_in_done"}, busy64, 0);
    repeat (3) step();
    check({tag, "_done_held"}, done64, 1);
    check({tag, "_result_held"}, res64, exp);
    start64 = 1'b0; clear64 = 1'b1;
    step();
    clear64 = 1'b0;
    check({tag, "_done_cleared"}, done64, 0);
    check({tag, "_result_cleared"}, res64, 0);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sm, input logic [15:0] exp);
    int cyc;
    mult8 = a; mcand8 = b; sm8 = sm; start8 = 1'b1;
    step();
    check({tag, "_busy_at_load"}, busy8, 1);
    mult8 = ~a; mcand8 = ~b;
    cyc = 0;
    while (!done8 && cyc < 40) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 5);
    check({tag, "_result"}, res8, exp);
    start8 = 1'b0; clear8 = 1'b1;
    step();
    clear8 = 1'b0;
    check({tag, "_done_cleared"}, done8, 0);
    check({tag, "_result_cleared"}, res8, 0);
  endtask

  initial begin
    int cyc;

    #12;
    check("rst_busy", busy64, 0);
    check("rst_done", done64, 0);
    check("rst_result", res64, 0);
    check("rst_result8", res8, 0);
    reset_n = 1'b1;
    step();

    run64("s_m19sq", 64'hFFFF_FFFF_FFFF_FFED, 64'hFFFF_FFFF_FFFF_FFED, 1'b1,
          128'h169);
    run64("u_m19sq", 64'hFFFF_FFFF_FFFF_FFED, 64'hFFFF_FFFF_FFFF_FFED, 1'b0,
          128'hFFFF_FFFF_FFFF_FFDA_0000_0000_0000_0169);
    run64("s_minneg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
          128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run64("s_7xm3", 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);

    run8("u8_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run8("s8_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
    run8("u8_zero", 8'h00, 8'hA5, 1'b0, 16'h0000);
    run8("u8_80sq", 8'h80, 8'h80, 1'b0, 16'h4000);
    run8("s8_80x7f", 8'h80, 8'h7F, 1'b1, 16'hC080);

    // Clear and start together in IDLE: clear wins, start on the next edge.
    mult64 = 64'd3; mcand64 = 64'd5; sm64 = 1'b0;
    start64 = 1'b1; clear64 = 1'b1;
    step();
    check("clr_start_idle_busy", busy64, 0);
    clear64 = 1'b0;
    step();
    check("start_after_clr_busy", busy64, 1);
    start64 = 1'b0;

    // Abort mid-EXEC at load+10.
    repeat (9) step();
    check("abort_pre_busy", busy64, 1);
    clear64 = 1'b1;
    step();
    clear64 = 1'b0;
    check("abort_busy", busy64, 0);
    check("abort_done", done64, 0);
    check("abort_result", res64, 0);
    cyc = 0;
    while (!done64 && cyc < 40) begin
      step();
      cyc++;
    end
    check("abort_no_done", done64, 0);

    run64("u_2p32sq", 64'h1_0000_0000, 64'h1_0000_0000, 1'b0,
          128'h1_0000_0000_0000_0000);

    // Asynchronous reset between clock edges mid-EXEC.
    mult64 = 64'd9; mcand64 = 64'd9; sm64 = 1'b1; start64 = 1'b1;
    step();
    start64 = 1'b0;
    repeat (4) step();
    check("areset_pre_busy", busy64, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_busy", busy64, 0);
    check("areset_done", done64, 0);
    check("areset_result", res64, 0);
    #1;
    reset_n = 1'b1;
    step();
    check("areset_idle_busy", busy64, 0);

    run64("s_zero", 64'd0, 64'd0, 1'b1, 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
